mem_requester: RTL
==================

MEM_REQUESTER -- requirements
Module: mem_requester

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, the number of request FIFO entries; it SHALL be a power of two, at least 2.
REQ-002 Port: clk, input, 1 bit, single clock; all state SHALL update on its rising edge.
REQ-003 Port: rst, input, 1 bit; reset SHALL be asynchronous and active-high.
REQ-004 Port: req_valid, input, 1 bit, pipeline request strobe.
REQ-005 Port: req_write, input, 1 bit; 1 selects a store, 0 selects a load.
REQ-006 Port: req_addr, input, 10 bits, word address.
REQ-007 Port: req_wdata, input, 32 bits, store data.
REQ-008 Port: req_ready, output, 1 bit, high when the FIFO can accept a request.
REQ-009 Port: MemRead, output, 1 bit, read strobe to the data-memory subsystem.
REQ-010 Port: MemWrite, output, 1 bit, write strobe to the data-memory subsystem.
REQ-011 Port: WordAddress, output, 10 bits, address to the data-memory subsystem.
REQ-012 Port: DataIn, output, 32 bits, write data to the data-memory subsystem.
REQ-013 Port: DataOut, input, 32 bits, read data from the data-memory subsystem.
REQ-014 Port: stall, input, 1 bit, data-memory busy (cache miss or fill in progress).
REQ-015 Port: resp_valid, output, 1 bit, one-cycle completion pulse.
REQ-016 Port: resp_is_write, output, 1 bit, completion type.
REQ-017 Port: resp_rdata, output, 32 bits, load result.
REQ-018 Port: busy, output, 1 bit, high when the FIFO is non-empty or the FSM is not in IDLE.

Function
REQ-019 The request FIFO SHALL hold {write, addr, wdata}, and req_ready SHALL equal !full.
REQ-020 A push SHALL occur on an edge where req_valid && req_ready.
- When full, no push occurs, even if a pop happens in the same cycle.
REQ-021 A simultaneous push and pop when not full SHALL leave the count unchanged.
REQ-022 The read and write pointers SHALL wrap modulo FIFO_DEPTH, and the count SHALL be kept in log2(FIFO_DEPTH)+1 bits.
REQ-023 The FSM SHALL have two states: IDLE and ISSUE.
REQ-024 IDLE: if the FIFO is non-empty, the FSM SHALL pop the head into registered outputs (WordAddress, DataIn, MemRead=!write, MemWrite=write) and go to ISSUE; otherwise MemRead and MemWrite SHALL be 0.
- Latency from push to first strobe is 1 cycle after the push edge, minimum.
REQ-025 ISSUE: WordAddress, DataIn, MemRead and MemWrite SHALL be held stable while stall=1.
REQ-026 The transaction SHALL complete on the first edge in ISSUE with stall=0.
REQ-027 On completion:
- resp_valid=1 for the next cycle only;
- resp_is_write is set from the type of the completed transaction;
- for a load, resp_rdata captures DataOut at the completing edge.
REQ-028 On completion with the FIFO non-empty, the FSM SHALL pop the next entry in the same edge and remain in ISSUE (back-to-back, no bubble).
REQ-029 On completion with the FIFO empty, the FSM SHALL go to IDLE and clear MemRead and MemWrite.
REQ-030 MemRead and MemWrite SHALL never both be 1.
REQ-031 Stores SHALL NOT alter resp_rdata, which holds its last load value.
REQ-032 Requests SHALL complete strictly in FIFO order.
REQ-033 stall while in IDLE SHALL be ignored.

Reset
REQ-034 rst=1 SHALL immediately, without waiting for a clock edge, set:
- FIFO empty, FSM in IDLE;
- MemRead=0, MemWrite=0, WordAddress=0, DataIn=0;
- resp_valid=0, resp_is_write=0, resp_rdata=0;
- req_ready=1, busy=0.
REQ-035 A reset asserted mid-transaction SHALL discard in-flight and queued requests, with no resp_valid pulse for them.
REQ-036 After reset deassertion, the first push SHALL behave as in REQ-024.

Verification
REQ-037 Load hit: push {read, 0x005}, stall=0, DataOut=0xDEADBEEF -> MemRead=1 for 1 cycle, then resp_valid=1, resp_is_write=0, resp_rdata=0xDEADBEEF.
REQ-038 Load miss: push {read, 0x040}, stall=1 for 5 cycles -> MemRead and WordAddress=0x040 stable for 6 cycles; a single resp_valid pulse occurs after stall falls.
REQ-039 Fill and overflow: 5 pushes while stall=1 -> req_ready=0 after the 5th accepted entry (4 queued plus 1 issuing); the 6th req_valid is not accepted; all 5 complete in order once stall=0.
REQ-040 Back-to-back: store {0x010, 0x12345678} then load 0x010, stall=0 -> MemWrite, then MemRead in consecutive cycles; resp_is_write=1, then 0; resp_rdata=DataOut of the second transaction.
REQ-041 Reset mid-miss: 3 queued, stall=1, rst pulsed -> MemRead=0 and req_ready=1 without a clock edge; no resp_valid afterward.
REQ-042 Every scenario SHALL include an assertion that MemRead && MemWrite is never 1.

Source files
------------

// File: rtl/mem_requester.sv
// Memory requester: queues load/store requests from the pipeline in a small FIFO
// and issues them one at a time to a stalling data-memory subsystem.
module mem_requester #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [9:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [9:0]  WordAddress,
  output logic [31:0] DataIn,
  input  logic [31:0] DataOut,
  input  logic        stall,
  output logic        resp_valid,
  output logic        resp_is_write,
  output logic [31:0] resp_rdata,
  output logic        busy,
  output logic [0:0]  o_dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 1 + 10 + 32;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ISSUE = 1'b1;

  logic [EW-1:0] r_fifo [FIFO_DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_count;
  logic [0:0]    r_state;

  logic          r_mem_read;
  logic          r_mem_write;
  logic [9:0]    r_word_addr;
  logic [31:0]   r_data_in;
  logic          r_resp_valid;
  logic          r_resp_is_write;
  logic [31:0]   r_resp_rdata;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [EW-1:0] w_head;

  // Handshake: a request is taken on any rising edge where req_valid && req_ready;
  // req_ready depends only on registered occupancy, never on req_valid.
  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_push  = req_valid && !w_full;
  assign w_pop   = !w_empty && ((r_state == S_IDLE) || !stall);
  assign w_head  = r_fifo[r_rd_ptr];

  assign req_ready     = !w_full;
  assign busy          = !w_empty || (r_state != S_IDLE);
  assign MemRead       = r_mem_read;
  assign MemWrite      = r_mem_write;
  assign WordAddress   = r_word_addr;
  assign DataIn        = r_data_in;
  assign resp_valid    = r_resp_valid;
  assign resp_is_write = r_resp_is_write;
  assign resp_rdata    = r_resp_rdata;
  assign o_dbg_state   = r_state;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= {req_write, req_addr, req_wdata};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // The same edge that completes a transaction may load the next one from the
  // FIFO head, so ISSUE can run back-to-back without an idle cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_mem_read      <= 1'b0;
      r_mem_write     <= 1'b0;
      r_word_addr     <= '0;
      r_data_in       <= '0;
      r_resp_valid    <= 1'b0;
      r_resp_is_write <= 1'b0;
      r_resp_rdata    <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_mem_write <= w_head[42];
            r_mem_read  <= !w_head[42];
            r_word_addr <= w_head[41:32];
            r_data_in   <= w_head[31:0];
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!stall) begin
            r_resp_valid    <= 1'b1;
            r_resp_is_write <= r_mem_write;
            if (!r_mem_write) r_resp_rdata <= DataOut;
            if (!w_empty) begin
              r_mem_write <= w_head[42];
              r_mem_read  <= !w_head[42];
              r_word_addr <= w_head[41:32];
              r_data_in   <= w_head[31:0];
            end else begin
              r_mem_read  <= 1'b0;
              r_mem_write <= 1'b0;
              r_state     <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
